led_band_fetch: RTL and testbench
=================================

Name: led_band_fetch

Overview:
- Upstream address sequencer and read-data collector for the LED band column memory.
- On each angle tick it sweeps band select, LED index and colour, and drives the field inputs of the band address mux. The mux turns these fields into the memory read address.
- It captures the memory read data after a fixed latency and streams one colour word per beat to the LED driver serializer over a valid/ready handshake.
- Sits between the rotation angle tracker and the driver shift stage.

Parameters:
- CURRENT_LED_WIDTH, 4, width of LED index; LED_COUNT = 2**CURRENT_LED_WIDTH LEDs per band.
- MULT_NUMBER, 4, number of bands; mult output is one-hot of this width.
- DATA_WIDTH, 8, memory read-data / colour word width.
- RD_LATENCY, 1, cycles from field presentation to valid r_data (1..3).
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- angle_tick, input, 1, one-cycle pulse: start a fetch for angle_in.
- angle_in, input, 6, angle slot sampled on angle_tick.
- current_led, output, CURRENT_LED_WIDTH, LED index to address mux.
- mult, output, MULT_NUMBER, one-hot band select to address mux.
- color, output, 2, colour index (0=R, 1=G, 2=B) to address mux.
- angle, output, 6, latched angle slot to address mux.
- r_data, input, DATA_WIDTH, memory read data, valid RD_LATENCY cycles after fields.
- px_data, output, DATA_WIDTH, colour word to serializer.
- px_last, output, 1, marks the final word of the angle sweep.
- px_valid, output, 1, px_data/px_last valid.
- px_ready, input, 1, serializer accepts the beat when px_valid and px_ready are both high.
- busy, output, 1, a sweep is in progress or the buffer is non-empty.
- overrun, output, 1, sticky flag: angle_tick arrived while busy.

Behaviour:
- Reset values: current_led=0, mult=1 (band 0), color=0, angle=0, px_valid=0, px_data=0, px_last=0, busy=0, overrun=0. FIFO and in-flight pipeline are cleared.
- Reset mid-sweep aborts immediately. In-flight reads are discarded and no px beat is produced after rst deasserts until the next angle_tick.
- FSM has two states:
  - IDLE: angle_tick latches angle_in into angle and moves to FETCH in the next cycle.
  - FETCH: issues reads, then returns to IDLE after the last issue. busy stays high until the FIFO drains.
- Issue order: color increments fastest (0,1,2), then current_led (0..LED_COUNT-1), then mult shifts left (band 0..MULT_NUMBER-1). One sweep is 3*LED_COUNT*MULT_NUMBER issues (192 at defaults).
- Issue rule: one field set per cycle, only when fifo_count + inflight < FIFO_DEPTH (credit-based). Otherwise the fields are held unchanged and nothing is issued.
- Read path: a RD_LATENCY-deep valid/last shift pipeline tags each issue. When the tag exits, r_data is written to the FIFO, so the FIFO never overflows by construction.
- Fields wrap to current_led=0, mult=1, color=0 after the final issue.
- px outputs come from the FIFO head, first-word fall-through. px_valid = FIFO non-empty. px_last is set only on the word from color=2, led=LED_COUNT-1, band MULT_NUMBER-1.
- FIFO handles simultaneous push and pop in the same cycle; the count is unchanged.
- Minimum latency: angle_tick in cycle 0, first issue in cycle 1, first px_valid in cycle 1+RD_LATENCY.
- With px_ready held high, one beat is produced per cycle with no bubbles.
- angle_tick while busy: ignored, the sweep continues with its latched angle, and overrun is set. overrun clears only on rst.
- angle_tick in the same cycle busy falls: busy is still high that cycle, so the tick is ignored and overrun is set.
- px_data holds stable while px_valid is high and px_ready is low.

Optional Feature:
- Macro LED_FETCH_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt [7:0]. It counts ignored angle_ticks, saturates at 255 and resets to 0 on rst. The overrun flag is unchanged.
- Undefined: no overrun_cnt port and no counter logic; only the sticky overrun flag exists.

Test Plan:
- Defaults, px_ready=1, angle_tick with angle_in=5 -> 192 consecutive beats. The first beat appears 2 cycles after the tick. px_last is high only on beat 191. Field order runs (color 0,1,2; led 0..15; mult 1,2,4,8). busy falls the cycle after the last beat.
- px_ready=0 for 20 cycles after the tick -> exactly FIFO_DEPTH reads issued, fields frozen, px_data stable. After px_ready rises, all 192 words arrive in order with no loss or duplication.
- Second angle_tick at cycle 50 of a sweep -> the sweep completes with angle=5, overrun=1, and no extra beats. With LED_FETCH_OVERRUN_CNT_EN defined, overrun_cnt=1.
- Assert rst at beat 100, release, then tick with angle_in=9 -> no stale beats. The new sweep starts at led 0, mult=1, color 0, angle=9.
- RD_LATENCY=3, FIFO_DEPTH=4, px_ready toggled randomly -> px_data sequence matches a memory model addressed by the issued fields. No FIFO overflow. The credit check is never violated.
- With LED_FETCH_OVERRUN_CNT_EN defined, 300 ticks all arriving while busy -> overrun_cnt saturates at 255.

Source files
------------

// File: rtl/led_band_fetch.sv
// Address sequencer and read-data collector for the LED band column memory.
// Optional LED_FETCH_OVERRUN_CNT_EN adds overrun_cnt, a saturating count of ignored angle ticks.
module led_band_fetch #(
  parameter int unsigned CURRENT_LED_WIDTH = 4,
  parameter int unsigned MULT_NUMBER       = 4,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned RD_LATENCY        = 1,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         angle_tick,
  input  logic [5:0]                   angle_in,
  output logic [CURRENT_LED_WIDTH-1:0] current_led,
  output logic [MULT_NUMBER-1:0]       mult,
  output logic [1:0]                   color,
  output logic [5:0]                   angle,
  input  logic [DATA_WIDTH-1:0]        r_data,
  output logic [DATA_WIDTH-1:0]        px_data,
  output logic                         px_last,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic                         busy,
  output logic                         overrun
`ifdef LED_FETCH_OVERRUN_CNT_EN
  ,
  output logic [7:0]                   overrun_cnt
`endif
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
  localparam logic [CURRENT_LED_WIDTH-1:0] LED_MAX = {CURRENT_LED_WIDTH{1'b1}};

  typedef enum logic {ST_IDLE, ST_FETCH} state_e;

  state_e                         state_q;
  logic [CURRENT_LED_WIDTH-1:0]   led_q;
  logic [MULT_NUMBER-1:0]         mult_q;
  logic [1:0]                     color_q;
  logic [5:0]                     angle_q;
  logic                           busy_q;
  logic                           overrun_q;

  logic [RD_LATENCY-1:0]          pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0]          pipe_last_q, pipe_last_d;

  logic [ENTRY_W-1:0]             fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]               fifo_cnt_q, fifo_cnt_d;

  logic                           accept_c, last_field_c, credit_ok_c, issue_c;
  logic                           exit_vld_c, exit_last_c, fifo_empty_c;
  logic                           push_c, pop_c, fetch_next_c;
  logic [SUM_W-1:0]               inflight_c;
  logic [ENTRY_W-1:0]             head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept_c     = angle_tick & ~busy_q;
  assign last_field_c = (color_q == 2'd2) & (led_q == LED_MAX) & mult_q[MULT_NUMBER-1];

  // Reads already issued but not yet landed in the FIFO.
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight_c = inflight_c + SUM_W'(pipe_vld_q[i]);
    end
  end

  assign credit_ok_c  = (SUM_W'(fifo_cnt_q) + inflight_c) < SUM_W'(FIFO_DEPTH);
  assign issue_c      = (state_q == ST_FETCH) & credit_ok_c;
  assign fetch_next_c = (state_q == ST_IDLE) ? accept_c : ~(issue_c & last_field_c);

  assign exit_vld_c   = pipe_vld_q[RD_LATENCY-1];
  assign exit_last_c  = pipe_last_q[RD_LATENCY-1];

  // Tag pipeline marks which cycles carry requested read data.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = issue_c;
    pipe_last_d[0] = issue_c & last_field_c;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
  end

  // First-word fall-through: an arriving word is visible the cycle it lands.
  assign fifo_empty_c = (fifo_cnt_q == '0);
  assign head_c       = fifo_mem_q[rd_ptr_q];
  assign px_valid     = ~fifo_empty_c | exit_vld_c;
  assign px_data      = ~fifo_empty_c ? head_c[DATA_WIDTH-1:0] :
                        (exit_vld_c ? r_data : '0);
  assign px_last      = ~fifo_empty_c ? head_c[DATA_WIDTH] : (exit_vld_c & exit_last_c);

  assign push_c = exit_vld_c;
  assign pop_c  = px_valid & px_ready;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_c, pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      led_q       <= '0;
      mult_q      <= MULT_NUMBER'(1);
      color_q     <= '0;
      angle_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      busy_q      <= fetch_next_c | (fifo_cnt_d != '0) | (|pipe_vld_d);
      overrun_q   <= overrun_q | (angle_tick & busy_q);

      if (push_c) begin
        fifo_mem_q[wr_ptr_q] <= {exit_last_c, r_data};
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            angle_q <= angle_in;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Colour fastest, then LED, then band; everything wraps after the last issue.
          if (issue_c) begin
            if (color_q == 2'd2) begin
              color_q <= '0;
              if (led_q == LED_MAX) begin
                led_q  <= '0;
                mult_q <= {mult_q[MULT_NUMBER-2:0], mult_q[MULT_NUMBER-1]};
              end else begin
                led_q <= led_q + CURRENT_LED_WIDTH'(1);
              end
            end else begin
              color_q <= color_q + 2'd1;
            end
            if (last_field_c) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign current_led = led_q;
  assign mult        = mult_q;
  assign color       = color_q;
  assign angle       = angle_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

`ifdef LED_FETCH_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt_q <= '0;
    end else if (angle_tick && busy_q && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_q <= overrun_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_led_band_fetch.sv
// Bench for led_band_fetch: default instance (latency 1) plus a latency-3 instance under random backpressure.
// Define LED_FETCH_OVERRUN_CNT_EN to also exercise overrun_cnt.
module tb_led_band_fetch;

  localparam int LEDS  = 16;
  localparam int BANDS = 4;
  localparam int SWEEP = 3 * LEDS * BANDS;

  logic clk;
  logic rst;

  logic       a_tick, a_px_ready, a_px_valid, a_px_last, a_busy, a_overrun;
  logic [5:0] a_angle_in, a_angle;
  logic [3:0] a_led, a_mult;
  logic [1:0] a_color;
  logic [7:0] a_r_data, a_px_data;

  logic       b_tick, b_px_ready, b_px_valid, b_px_last, b_busy, b_overrun;
  logic [5:0] b_angle_in, b_angle;
  logic [3:0] b_led, b_mult;
  logic [1:0] b_color;
  logic [7:0] b_r_data, b_px_data;
  logic [7:0] b_rd_pipe [3];

`ifdef LED_FETCH_OVERRUN_CNT_EN
  logic [7:0] a_overrun_cnt, b_overrun_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  int beats_a = 0, beats_b = 0, issues_b = 0;
  logic [9:0] prev_fields_b;
  bit rand_b = 0;
  bit b_hold = 0;
  logic [7:0] b_hold_data;

  led_band_fetch u_dut_a (
    .clk(clk), .rst(rst), .angle_tick(a_tick), .angle_in(a_angle_in),
    .current_led(a_led), .mult(a_mult), .color(a_color), .angle(a_angle),
    .r_data(a_r_data), .px_data(a_px_data), .px_last(a_px_last), .px_valid(a_px_valid),
    .px_ready(a_px_ready), .busy(a_busy), .overrun(a_overrun)
`ifdef LED_FETCH_OVERRUN_CNT_EN
    , .overrun_cnt(a_overrun_cnt)
`endif
  );

  led_band_fetch #(.RD_LATENCY(3), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .angle_tick(b_tick), .angle_in(b_angle_in),
    .current_led(b_led), .mult(b_mult), .color(b_color), .angle(b_angle),
    .r_data(b_r_data), .px_data(b_px_data), .px_last(b_px_last), .px_valid(b_px_valid),
    .px_ready(b_px_ready), .busy(b_busy), .overrun(b_overrun)
`ifdef LED_FETCH_OVERRUN_CNT_EN
    , .overrun_cnt(b_overrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_word(input logic [5:0] ang, input logic [3:0] m,
                                          input logic [3:0] l, input logic [1:0] c);
    return 8'((32'(ang) * 29) + (32'(m) * 53) + (32'(l) * 17) + (32'(c) * 71)
              + (32'(m) * 32'(l) * 3));
  endfunction

  // Column memory models: synchronous ROM with the read latency of each instance.
  always @(posedge clk) a_r_data <= mem_word(a_angle, a_mult, a_led, a_color);
  always @(posedge clk) begin
    b_rd_pipe[0] <= mem_word(b_angle, b_mult, b_led, b_color);
    b_rd_pipe[1] <= b_rd_pipe[0];
    b_rd_pipe[2] <= b_rd_pipe[1];
  end
  assign b_r_data = b_rd_pipe[2];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep(input bit inst_b, input logic [5:0] ang);
    for (int b = 0; b < BANDS; b++)
      for (int l = 0; l < LEDS; l++)
        for (int c = 0; c < 3; c++) begin
          logic [8:0] w;
          w = {(b == BANDS-1 && l == LEDS-1 && c == 2), mem_word(ang, 4'(1 << b), 4'(l), 2'(c))};
          if (inst_b) exp_b.push_back(w);
          else        exp_a.push_back(w);
        end
  endtask

  // Called at a falling edge after inputs are set; scores this cycle's handshakes.
  task automatic step();
    logic [8:0] w;
    logic [9:0] fields_b;
    if (rand_b) b_px_ready = 1'($urandom_range(0, 1));
    #1;
    if (a_px_valid && a_px_ready) begin
      check("a_extra_beat", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        w = exp_a.pop_front();
        check("a_px_data", 32'(a_px_data), 32'(w[7:0]));
        check("a_px_last", 32'(a_px_last), 32'(w[8]));
      end
      beats_a++;
    end
    fields_b = {b_led, b_mult, b_color};
    if (fields_b != prev_fields_b) issues_b++;
    prev_fields_b = fields_b;
    check("b_credit", 32'((issues_b - beats_b) <= 4), 32'd1);
    if (b_hold) begin
      check("b_hold_valid", 32'(b_px_valid), 32'd1);
      check("b_hold_data", 32'(b_px_data), 32'(b_hold_data));
    end
    b_hold      = b_px_valid && !b_px_ready;
    b_hold_data = b_px_data;
    if (b_px_valid && b_px_ready) begin
      check("b_extra_beat", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        w = exp_b.pop_front();
        check("b_px_data", 32'(b_px_data), 32'(w[7:0]));
        check("b_px_last", 32'(b_px_last), 32'(w[8]));
      end
      beats_b++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  task automatic check_reset_a();
    check("rst_led", 32'(a_led), 32'd0);
    check("rst_mult", 32'(a_mult), 32'd1);
    check("rst_color", 32'(a_color), 32'd0);
    check("rst_angle", 32'(a_angle), 32'd0);
    check("rst_px_valid", 32'(a_px_valid), 32'd0);
    check("rst_px_data", 32'(a_px_data), 32'd0);
    check("rst_px_last", 32'(a_px_last), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_overrun", 32'(a_overrun), 32'd0);
  endtask

  initial begin
    int lat;
    int base;
    int n;
    rst = 1'b1;
    a_tick = 1'b0; a_angle_in = '0; a_px_ready = 1'b1;
    b_tick = 1'b0; b_angle_in = '0; b_px_ready = 1'b1;
    prev_fields_b = {4'd0, 4'd1, 2'd0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_a();
    idle(2);

    // Full sweep, ready held high
    a_tick = 1'b1; a_angle_in = 6'd5; push_sweep(0, 6'd5);
    step();
    a_tick = 1'b0;
    check("t1_angle", 32'(a_angle), 32'd5);
    check("t1_first_fields", 32'({a_led, a_mult, a_color}), 32'({4'd0, 4'd1, 2'd0}));
    check("t1_busy_rise", 32'(a_busy), 32'd1);
    lat = 1;
    while (!a_px_valid && lat < 8) begin
      step();
      lat++;
    end
    check("t1_latency", 32'(lat), 32'd2);
    for (int i = 0; i < SWEEP; i++) begin
      check("t1_no_bubble", 32'(a_px_valid), 32'd1);
      check("t1_busy_hold", 32'(a_busy), 32'd1);
      step();
    end
    check("t1_busy_fall", 32'(a_busy), 32'd0);
    check("t1_valid_end", 32'(a_px_valid), 32'd0);
    check("t1_overrun", 32'(a_overrun), 32'd0);
    check("t1_wrap", 32'({a_led, a_mult, a_color}), 32'({4'd0, 4'd1, 2'd0}));
    idle(2);

    // Backpressure: ready low for 20 cycles after the tick
    a_px_ready = 1'b0;
    a_tick = 1'b1; a_angle_in = 6'd5; push_sweep(0, 6'd5);
    step();
    a_tick = 1'b0;
    for (int i = 1; i < 20; i++) begin
      if (a_px_valid) check("t2_stall_data", 32'(a_px_data), 32'(exp_a[0][7:0]));
      step();
    end
    check("t2_frozen_led", 32'(a_led), 32'd1);
    check("t2_frozen_color", 32'(a_color), 32'd1);
    check("t2_frozen_mult", 32'(a_mult), 32'd1);
    check("t2_stall_valid", 32'(a_px_valid), 32'd1);
    a_px_ready = 1'b1;
    drain(600);
    idle(3);

    // Second tick mid-sweep is ignored
    a_tick = 1'b1; a_angle_in = 6'd5; push_sweep(0, 6'd5);
    step();
    a_tick = 1'b0;
    repeat (49) step();
    a_tick = 1'b1; a_angle_in = 6'd7;
    step();
    a_tick = 1'b0;
    check("t3_angle_kept", 32'(a_angle), 32'd5);
    drain(400);
    idle(4);
    check("t3_overrun", 32'(a_overrun), 32'd1);
`ifdef LED_FETCH_OVERRUN_CNT_EN
    check("t3_overrun_cnt", 32'(a_overrun_cnt), 32'd1);
`endif

    // Reset mid-sweep, then a fresh sweep with a new angle
    a_tick = 1'b1; a_angle_in = 6'd5; push_sweep(0, 6'd5);
    step();
    a_tick = 1'b0;
    base = beats_a;
    n = 0;
    while (beats_a < base + 100 && n < 400) begin
      step();
      n++;
    end
    check("t4_reach_100", 32'(beats_a - base), 32'd100);
    rst = 1'b1;
    exp_a.delete();
    #1;
    check("t4_async_valid", 32'(a_px_valid), 32'd0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    check_reset_a();
`ifdef LED_FETCH_OVERRUN_CNT_EN
    check("t4_cnt_rst", 32'(a_overrun_cnt), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      check("t4_no_stale", 32'(a_px_valid), 32'd0);
      step();
    end
    a_tick = 1'b1; a_angle_in = 6'd9; push_sweep(0, 6'd9);
    step();
    a_tick = 1'b0;
    check("t4_new_fields", 32'({a_led, a_mult, a_color}), 32'({4'd0, 4'd1, 2'd0}));
    check("t4_new_angle", 32'(a_angle), 32'd9);
    drain(400);
    idle(3);

    // Latency-3 instance with random backpressure
    b_tick = 1'b1; b_angle_in = 6'd33; push_sweep(1, 6'd33);
    rand_b = 1;
    step();
    b_tick = 1'b0;
    drain(3000);
    rand_b = 0;
    b_px_ready = 1'b1;
    idle(5);
    check("t5_issue_total", 32'(issues_b), 32'(SWEEP));
    check("t5_busy_end", 32'(b_busy), 32'd0);
    check("t5_overrun", 32'(b_overrun), 32'd0);

`ifdef LED_FETCH_OVERRUN_CNT_EN
    // Counter saturation with ticks held while stalled
    a_px_ready = 1'b0;
    a_tick = 1'b1; a_angle_in = 6'd12; push_sweep(0, 6'd12);
    step();
    repeat (300) step();
    a_tick = 1'b0;
    check("t6_cnt_sat", 32'(a_overrun_cnt), 32'd255);
    check("t6_angle", 32'(a_angle), 32'd12);
    a_px_ready = 1'b1;
    drain(600);
    idle(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
